// File: rtl/led_pkg.sv
// Shared constants and scan state encoding for the LED matrix scanner.
// Pixel word layout and matrix geometry live here.
package led_pkg;

    localparam int LED_ROWS   = 8;
    localparam int LED_COLS   = 8;
    localparam int PIX_STORED = 3;
    localparam int PIX_G      = 2;
    localparam int PIX_R      = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BLANK,
        LATCH,
        DWELL
    } scan_state_e;

    function automatic logic [LED_ROWS-1:0] row_onehot(input logic [2:0] r);
        return LED_ROWS'(1) << r;
    endfunction

endpackage

// File: rtl/led_scan_if.sv
// Frame RAM read port shared between the scanner and the pen/write side.
// The scanner is master; the RAM arbiter/storage is slave.
interface led_scan_if;

    logic       ram_rd;
    logic [2:0] ram_row;
    logic [2:0] ram_col;
    logic       ram_gnt;
    logic [3:0] ram_data;

    modport master (
        output ram_rd,
        output ram_row,
        output ram_col,
        input  ram_gnt,
        input  ram_data
    );

    modport slave (
        input  ram_rd,
        input  ram_row,
        input  ram_col,
        output ram_gnt,
        output ram_data
    );

endinterface

// File: rtl/led_scan.sv
// Row-by-row reader of the 8x8 frame RAM driving a bi-colour LED matrix.
// Every output is registered from next-state values; dwell/blank share one counter.
module led_scan
    import led_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    led_scan_if.master          ram,
    output logic [LED_ROWS-1:0] row_sel,
    output logic [LED_COLS-1:0] col_r,
    output logic [LED_COLS-1:0] col_g,
    output logic                frame_start,
    output logic                busy
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);

    scan_state_e         state_q, state_d;
    logic [2:0]          row_q, row_d;
    logic [3:0]          issue_q, issue_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [2:0]          cap_col_q, cap_col_d;
    logic [LED_COLS-1:0] shr_q, shr_d;
    logic [LED_COLS-1:0] shg_q, shg_d;
    logic                rd_q, rd_d;
    logic [2:0]          rrow_q, rrow_d;
    logic [2:0]          rcol_q, rcol_d;
    logic [LED_ROWS-1:0] rsel_q, rsel_d;
    logic [LED_COLS-1:0] cr_q, cr_d;
    logic [LED_COLS-1:0] cg_q, cg_d;
    logic                fs_q, fs_d;
    logic                busy_q, busy_d;
    logic                accept;

    assign accept = rd_q & ram.ram_gnt;

    // Next-state: scan sequencing, read issue, capture into the shadow row.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        issue_d   = issue_q;
        cnt_d     = cnt_q;
        pend_d    = 1'b0;
        cap_col_d = cap_col_q;
        shr_d     = shr_q;
        shg_d     = shg_q;
        if (!en) begin
            state_d = IDLE;
            row_d   = '0;
            issue_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    row_d   = '0;
                    issue_d = '0;
                end
                FETCH: begin
                    if (accept) begin
                        issue_d   = issue_q + 4'd1;
                        pend_d    = 1'b1;
                        cap_col_d = rcol_q;
                    end
                    if (pend_q) begin
                        shr_d[cap_col_q] = ram.ram_data[PIX_STORED] & ram.ram_data[PIX_R];
                        shg_d[cap_col_q] = ram.ram_data[PIX_STORED] & ram.ram_data[PIX_G];
                        if (cap_col_q == 3'd7) begin
                            state_d = BLANK;
                            cnt_d   = BLANK_LD;
                        end
                    end
                end
                BLANK: begin
                    if (cnt_q == '0) state_d = LATCH;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                LATCH: begin
                    state_d = DWELL;
                    cnt_d   = DWELL_LD;
                end
                DWELL: begin
                    if (cnt_q == '0) begin
                        state_d = FETCH;
                        row_d   = row_q + 3'd1;
                        issue_d = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output next-values derived from the upcoming state so outputs stay registered.
    always_comb begin
        rd_d   = (state_d == FETCH) && !issue_d[3];
        rrow_d = rd_d ? row_d : 3'd0;
        rcol_d = rd_d ? issue_d[2:0] : 3'd0;
        busy_d = (state_d != IDLE);
        rsel_d = rsel_q;
        cr_d   = cr_q;
        cg_d   = cg_q;
        fs_d   = 1'b0;
        unique case (state_d)
            IDLE, BLANK: begin
                rsel_d = '0;
                cr_d   = '0;
                cg_d   = '0;
            end
            LATCH: begin
                rsel_d = row_onehot(row_d);
                cr_d   = shr_q;
                cg_d   = shg_q;
                fs_d   = (row_d == 3'd0);
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            issue_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            cap_col_q <= '0;
            shr_q     <= '0;
            shg_q     <= '0;
            rd_q      <= 1'b0;
            rrow_q    <= '0;
            rcol_q    <= '0;
            rsel_q    <= '0;
            cr_q      <= '0;
            cg_q      <= '0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            issue_q   <= issue_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cap_col_q <= cap_col_d;
            shr_q     <= shr_d;
            shg_q     <= shg_d;
            rd_q      <= rd_d;
            rrow_q    <= rrow_d;
            rcol_q    <= rcol_d;
            rsel_q    <= rsel_d;
            cr_q      <= cr_d;
            cg_q      <= cg_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    assign ram.ram_rd  = rd_q;
    assign ram.ram_row = rrow_q;
    assign ram.ram_col = rcol_q;
    assign row_sel     = rsel_q;
    assign col_r       = cr_q;
    assign col_g       = cg_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_led_scan.sv
// Scoreboard bench for led_scan: expected latched rows are queued by stimulus
// and popped by a monitor whenever the matrix latches a new row.
module tb_led_scan;

    localparam int DW = 4;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [7:0] row_sel, col_r, col_g;
    logic frame_start, busy;

    always #5 clk = ~clk;

    led_scan_if bus ();

    led_scan #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .ram(bus),
        .row_sel(row_sel),
        .col_r(col_r),
        .col_g(col_g),
        .frame_start(frame_start),
        .busy(busy)
    );

    logic [3:0] mem [8][8];

    // RAM model: data one clock after an accepted read, noise otherwise.
    always @(posedge clk) begin
        if (bus.ram_rd && bus.ram_gnt) bus.ram_data <= mem[bus.ram_row][bus.ram_col];
        else                           bus.ram_data <= 4'($urandom);
    end

    typedef struct {
        logic [7:0] rs;
        logic [7:0] cr;
        logic [7:0] cg;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    bit timing_chk = 1'b0;
    bit gnt_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int r);
        exp_t e;
        e.rs = 8'(1 << r);
        for (int c = 0; c < 8; c++) begin
            e.cr[c] = mem[r][c][3] & mem[r][c][1];
            e.cg[c] = mem[r][c][3] & mem[r][c][2];
        end
        e.fs = (r == 0);
        return e;
    endfunction

    // Monitor: pop and compare on every row latch; timing checks when enabled.
    logic [7:0] prev_rs = '0;
    int cyc = 0, last_lat = -1, last_fs = -1, zrun = 0;
    exp_t me;
    always @(negedge clk) begin
        cyc++;
        if (rst || !busy) begin
            last_lat = -1;
            last_fs  = -1;
            zrun     = 0;
        end else if (row_sel != 0 && prev_rs == 0) begin
            chk("latch_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("row_sel", 32'(row_sel), 32'(me.rs));
                chk("col_r", 32'(col_r), 32'(me.cr));
                chk("col_g", 32'(col_g), 32'(me.cg));
                chk("frame_start", 32'(frame_start), 32'(me.fs));
            end
            if (timing_chk && last_lat >= 0) begin
                chk("row_period", 32'(cyc - last_lat), 16);
                chk("blank_len", 32'(zrun), BL);
            end
            if (timing_chk && frame_start && last_fs >= 0)
                chk("frame_period", 32'(cyc - last_fs), 128);
            last_lat = cyc;
            if (frame_start) last_fs = cyc;
            zrun = 0;
        end else begin
            chk("fs_only_at_latch", 32'(frame_start), 0);
            if (row_sel == 0) zrun++;
            else              zrun = 0;
        end
        prev_rs = row_sel;
    end

    task automatic tick;
        @(negedge clk);
        if (gnt_rand) bus.ram_gnt = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_rows(input int first, input int n);
        for (int i = 0; i < n; i++) q.push_back(model((first + i) % 8));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 0);
        q.delete();
    endtask

    task automatic stop_scan;
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_row_sel"}, 32'(row_sel), 0);
        chk({tag, "_col_r"}, 32'(col_r), 0);
        chk({tag, "_col_g"}, 32'(col_g), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_ram_rd"}, 32'(bus.ram_rd), 0);
    endtask

    initial begin
        int start, acc, stall, n, lat;
        bit held_ok;
        rst = 1'b1;
        en = 1'b0;
        bus.ram_gnt = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mem[r][c] = 4'h0;
        repeat (3) tick();
        chk_dark("reset");
        chk("reset_ram_row", 32'(bus.ram_row), 0);
        chk("reset_ram_col", 32'(bus.ram_col), 0);
        rst = 1'b0;
        tick();

        mem[0][0] = 4'b1010;
        mem[0][7] = 4'b1100;
        mem[3][2] = 4'b0110;
        bus.ram_gnt = 1'b1;
        timing_chk = 1'b1;
        push_rows(0, 9);
        en = 1'b1;
        wait_drain(400);
        timing_chk = 1'b0;
        stop_scan();

        push_rows(0, 1);
        en = 1'b1;
        start = -1; acc = 0; stall = 0; n = 0; lat = -1; held_ok = 1'b1;
        while (lat < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (stall > 0) begin
                bus.ram_gnt = 1'b0;
                if (!(bus.ram_rd && bus.ram_col == 3'd3)) held_ok = 1'b0;
                stall--;
            end else begin
                bus.ram_gnt = 1'b1;
            end
            if (bus.ram_rd && start < 0) start = n;
            if (bus.ram_rd && bus.ram_gnt) begin
                acc++;
                if (acc == 3) stall = 5;
            end
            if (row_sel != 0) lat = n;
        end
        chk("stall_col_held", 32'(held_ok), 1);
        chk("stall_accepts", 32'(acc), 8);
        chk("stall_fetch_plus_blank", 32'(lat - start), 16);
        wait_drain(50);
        stop_scan();

        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) mem[r][c] = 4'($urandom);
            gnt_rand = 1'b1;
            push_rows(0, 10);
            en = 1'b1;
            wait_drain(1500);
            gnt_rand = 1'b0;
            bus.ram_gnt = 1'b1;
            stop_scan();
        end

        push_rows(0, 5);
        en = 1'b1;
        wait_drain(300);
        n = 0;
        while (!(bus.ram_rd && bus.ram_row == 3'd5) && n < 100) begin
            tick();
            n++;
        end
        chk("row5_fetch", 32'({bus.ram_rd, bus.ram_row}), 32'({1'b1, 3'd5}));
        repeat (3) tick();
        en = 1'b0;
        tick();
        chk_dark("en_drop");
        push_rows(0, 1);
        en = 1'b1;
        wait_drain(100);
        stop_scan();

        push_rows(0, 2);
        en = 1'b1;
        wait_drain(200);
        tick();
        chk("dwell_row1", 32'(row_sel), 32'h02);
        rst = 1'b1;
        tick();
        chk_dark("rst_dwell");
        rst = 1'b0;
        push_rows(0, 1);
        wait_drain(100);
        stop_scan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
